range_sensor_emulator: RTL and testbench
========================================

# range_sensor_emulator

Sensor-side counterpart of the range-sensor controller: emulates an HC-SR04-style ultrasonic module inside the FPGA so the MicroBlaze MCS range-sensor subsystem can be exercised without hardware. It watches the controller's trigger line, qualifies the trigger pulse, waits a fixed burst delay, and drives an echo pulse whose width is programmed in clock cycles. It then enforces a re-trigger holdoff. It sits between the range-sensor core's `trig_o`/`echo_i` pins in loopback builds and simulation benches.

## Interface
- `MIN_TRIG`, default 32'd1_000: minimum trigger high time in cycles (10 µs at 100 MHz).
- `BURST_DLY`, default 32'd46_000: cycles from accepted trigger fall to echo rise.
- `MAX_ECHO`, default 32'd2_320_000: echo width used for out-of-range/no-object.
- `HOLDOFF`, default 32'd6_000_000: cycles after echo fall during which triggers are ignored.
- `clk_i` in, 1: system clock.
- `rst_ni` in, 1: reset. It is asynchronous and active-low.
- `enable_i` in, 1: emulator enable. When low, the block returns to IDLE on the next cycle.
- `trig_i` in, 1: trigger from the controller, treated as asynchronous.
- `echo_len_i` in, 32: requested echo width in cycles. It is sampled at trigger acceptance.
- `echo_o` out, 1: emulated echo.
- `busy_o` out, 1: high in every state except IDLE and TRIG_HIGH.
- `trig_err_o` out, 1: one-cycle pulse when a trigger shorter than `MIN_TRIG` ends.
- `echo_cnt_o` out, 16: number of completed echoes. It wraps at 16'hFFFF→0.
- `state_o` out, 3: current state encoding, for debug.

## Operation
- `trig_i` passes through a 2-FF synchronizer; the result is `trig_s`. All FSM decisions use `trig_s`.
- IDLE: echo low. If `enable_i` and `trig_s`=1, go to TRIG_HIGH with `cnt`=1.
- TRIG_HIGH: `cnt` increments while `trig_s`=1 and saturates at 32'hFFFF_FFFF. When `trig_s`=0, the block checks the count:
  - `cnt` ≥ `MIN_TRIG`: latch `len_eff` and go to BURST with `cnt`=`BURST_DLY`-1.
  - Otherwise: pulse `trig_err_o` and return to IDLE.
- `len_eff` is chosen as follows:
  - `echo_len_i`=0 → `MAX_ECHO`.
  - `echo_len_i` > `MAX_ECHO` → `MAX_ECHO`.
  - Otherwise → `echo_len_i`.
- BURST: `cnt` counts down. At `cnt`=0, go to ECHO with `cnt`=`len_eff`-1.
- ECHO: `echo_o`=1 and `cnt` counts down. At `cnt`=0, go to HOLDOFF with `cnt`=`HOLDOFF`-1 and increment `echo_cnt_o`.
- HOLDOFF: `cnt` counts down. At `cnt`=0, go to IDLE. `trig_s` is ignored throughout.
- Triggers arriving in BURST, ECHO or HOLDOFF are ignored. They do not queue and do not assert `trig_err_o`.
- `enable_i`=0 in any state: next state is IDLE and `echo_o` drops on the next edge. A truncated echo does not increment `echo_cnt_o`.
- Trigger held high indefinitely: the block stays in TRIG_HIGH with `cnt` saturated, and accepts on the eventual fall.
- `echo_o`, `busy_o` and `state_o` are Moore outputs decoded from the state register.
- `trig_err_o` is registered.
- All counters are 32-bit unsigned. Parameters must be ≥ 1, and a violation is flagged by a simulation assertion.

## Timing
- Reset (`rst_ni`=0, asynchronous): state is IDLE, `cnt`=0 and `len_eff`=0. All outputs are 0, including `echo_cnt_o` and both synchronizer flops.
- Reset asserted mid-echo: `echo_o` falls immediately, without waiting for a clock edge.
- Synchronizer latency is 2 cycles.
- Let edge E be the first clock edge that samples `trig_i`=0 after an accepted trigger.
- The FSM enters BURST at edge E+2.
- `echo_o` rises at edge E+2+`BURST_DLY`.
- `echo_o` stays high for exactly `len_eff` cycles.
- `echo_cnt_o` updates on the same edge that `echo_o` falls.
- The next trigger can be recognised at the earliest `HOLDOFF` cycles after the echo falls.
- `trig_err_o` is high for the single cycle following edge E+2.

## Structure
- Package `range_sensor_emu_pkg` holds:
  - `emu_state_t` enum: IDLE=0, TRIG_HIGH=1, BURST=2, ECHO=3, HOLDOFF=4.
  - Default parameter constants.
- Sub-module `sync_2ff` is a 1-bit two-flop synchronizer with asynchronous active-low reset to 0. It is reusable by the controller side.
- Main module contents:
  - one `always_ff` for state, `cnt`, `len_eff`, `echo_cnt` and `trig_err`;
  - one `always_comb` for next-state logic.

## Test plan
All scenarios use small parameters: `MIN_TRIG`=10, `BURST_DLY`=20, `MAX_ECHO`=100, `HOLDOFF`=50.
- Nominal: `trig_i` high 12 cycles, `echo_len_i`=37 → `echo_o` rises at E+22, stays high exactly 37 cycles; `echo_cnt_o` goes 0→1.
- Short trigger: `trig_i` high 5 cycles → one `trig_err_o` pulse; `echo_o` stays low; `echo_cnt_o` unchanged.
- Clamp and no-object: `echo_len_i`=500, then 0 → both echoes are 100 cycles wide.
- Holdoff: valid trigger issued 10 cycles after echo fall → ignored, no echo. A valid trigger at 60 cycles after echo fall → echo produced.
- Abort paths:
  - `enable_i` dropped mid-ECHO → `echo_o` low the next cycle, `echo_cnt_o` unchanged, state IDLE.
  - `rst_ni` pulsed mid-BURST → all outputs 0 immediately.
- Wrap: preload by forcing `echo_cnt` to 16'hFFFF, then run one echo → `echo_cnt_o`=0.

Source files
------------

// File: rtl/range_sensor_emu_pkg.sv
// Shared types and defaults for the HC-SR04-style range sensor emulator.
package range_sensor_emu_pkg;

  typedef enum logic [2:0] {
    StIdle     = 3'd0,
    StTrigHigh = 3'd1,
    StBurst    = 3'd2,
    StEcho     = 3'd3,
    StHoldoff  = 3'd4
  } emu_state_t;

  // Defaults assume a 100 MHz system clock.
  localparam int unsigned DefMinTrig  = 32'd1_000;
  localparam int unsigned DefBurstDly = 32'd46_000;
  localparam int unsigned DefMaxEcho  = 32'd2_320_000;
  localparam int unsigned DefHoldoff  = 32'd6_000_000;

  // A zero or over-long request means "no object": answer with the full-range echo.
  function automatic logic [31:0] clamp_echo_len(input logic [31:0] req,
                                                 input logic [31:0] max_len);
    if (req == 32'd0 || req > max_len) begin
      return max_len;
    end
    return req;
  endfunction

endpackage

// File: rtl/sync_2ff.sv
// Single-bit two-flop synchronizer, asynchronous active-low reset to 0.
module sync_2ff (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic d_i,
  output logic q_o
);

  logic meta_q;
  logic sync_q;

  // Two back-to-back flops resolve metastability on the asynchronous input.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule

// File: rtl/range_sensor_emulator.sv
// Emulated ultrasonic module: qualifies a trigger, waits the burst delay,
// drives a programmable echo, then holds off re-triggering.
module range_sensor_emulator
  import range_sensor_emu_pkg::*;
#(
  parameter int unsigned MIN_TRIG  = DefMinTrig,
  parameter int unsigned BURST_DLY = DefBurstDly,
  parameter int unsigned MAX_ECHO  = DefMaxEcho,
  parameter int unsigned HOLDOFF   = DefHoldoff
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        enable_i,
  input  logic        trig_i,
  input  logic [31:0] echo_len_i,
  output logic        echo_o,
  output logic        busy_o,
  output logic        trig_err_o,
  output logic [15:0] echo_cnt_o,
  output logic [2:0]  state_o
);

  logic        trig_s;
  emu_state_t  state_q, state_d;
  logic [31:0] cnt_q, cnt_d;
  logic [31:0] len_eff_q, len_eff_d;
  logic [15:0] echo_cnt_q, echo_cnt_d;
  logic        trig_err_q, trig_err_d;

  sync_2ff u_trig_sync (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .d_i    (trig_i),
    .q_o    (trig_s)
  );

  // Zero-valued parameters would underflow the counter reloads.
  always_ff @(posedge clk_i) begin
    assert (MIN_TRIG != 0 && BURST_DLY != 0 && MAX_ECHO != 0 && HOLDOFF != 0)
      else $error("range_sensor_emulator: all timing parameters must be >= 1");
  end

  // State register plus the counters and flags that move with it.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= StIdle;
      cnt_q      <= 32'd0;
      len_eff_q  <= 32'd0;
      echo_cnt_q <= 16'd0;
      trig_err_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      len_eff_q  <= len_eff_d;
      echo_cnt_q <= echo_cnt_d;
      trig_err_q <= trig_err_d;
    end
  end

  // Next-state logic; a dropped enable overrides everything and parks in idle.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    len_eff_d  = len_eff_q;
    echo_cnt_d = echo_cnt_q;
    trig_err_d = 1'b0;

    if (!enable_i) begin
      state_d = StIdle;
      cnt_d   = 32'd0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (trig_s) begin
            state_d = StTrigHigh;
            cnt_d   = 32'd1;
          end
        end
        StTrigHigh: begin
          if (trig_s) begin
            // Saturate so an endlessly held trigger is still accepted on release.
            if (cnt_q != 32'hFFFF_FFFF) begin
              cnt_d = cnt_q + 32'd1;
            end
          end else if (cnt_q >= MIN_TRIG) begin
            len_eff_d = clamp_echo_len(echo_len_i, MAX_ECHO);
            state_d   = StBurst;
            cnt_d     = BURST_DLY - 32'd1;
          end else begin
            trig_err_d = 1'b1;
            state_d    = StIdle;
            cnt_d      = 32'd0;
          end
        end
        StBurst: begin
          if (cnt_q == 32'd0) begin
            state_d = StEcho;
            cnt_d   = len_eff_q - 32'd1;
          end else begin
            cnt_d = cnt_q - 32'd1;
          end
        end
        StEcho: begin
          if (cnt_q == 32'd0) begin
            state_d    = StHoldoff;
            cnt_d      = HOLDOFF - 32'd1;
            echo_cnt_d = echo_cnt_q + 16'd1;
          end else begin
            cnt_d = cnt_q - 32'd1;
          end
        end
        StHoldoff: begin
          if (cnt_q == 32'd0) begin
            state_d = StIdle;
          end else begin
            cnt_d = cnt_q - 32'd1;
          end
        end
        default: begin
          state_d = StIdle;
          cnt_d   = 32'd0;
        end
      endcase
    end
  end

  // Moore outputs decoded straight from the state register.
  always_comb begin
    echo_o  = (state_q == StEcho);
    busy_o  = !(state_q == StIdle || state_q == StTrigHigh);
    state_o = state_q;
  end

  assign trig_err_o = trig_err_q;
  assign echo_cnt_o = echo_cnt_q;

endmodule

// File: tb/tb_range_sensor_emulator.sv
// Bench for range_sensor_emulator: directed scenarios plus random triggers,
// checked every cycle against a timeline-based model of the echo sequence.
module tb_range_sensor_emulator;

  localparam int unsigned MinTrig  = 10;
  localparam int unsigned BurstDly = 20;
  localparam int unsigned MaxEcho  = 100;
  localparam int unsigned Holdoff  = 50;

  logic        clk_i;
  logic        rst_ni;
  logic        enable_i;
  logic        trig_i;
  logic [31:0] echo_len_i;
  logic        echo_o;
  logic        busy_o;
  logic        trig_err_o;
  logic [15:0] echo_cnt_o;
  logic [2:0]  state_o;

  range_sensor_emulator #(
    .MIN_TRIG  (MinTrig),
    .BURST_DLY (BurstDly),
    .MAX_ECHO  (MaxEcho),
    .HOLDOFF   (Holdoff)
  ) dut (
    .clk_i      (clk_i),
    .rst_ni     (rst_ni),
    .enable_i   (enable_i),
    .trig_i     (trig_i),
    .echo_len_i (echo_len_i),
    .echo_o     (echo_o),
    .busy_o     (busy_o),
    .trig_err_o (trig_err_o),
    .echo_cnt_o (echo_cnt_o),
    .state_o    (state_o)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  int     n_checks = 0;
  int     n_fail   = 0;
  longint cyc      = 0;

  task automatic check(input string nm, input longint act, input longint exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Model: an accepted trigger schedules absolute edge numbers for the burst start,
  // echo rise, echo fall and return to idle; outputs follow from those windows.
  bit          s1 = 0, s2 = 0, ts;
  bit          m_sched = 0;
  int unsigned m_high  = 0;
  longint      m_bs, m_rise, m_fall, m_idle;
  longint      m_err_at = -1;
  logic [15:0] m_cnt    = 16'd0;
  longint      len_eff;
  logic        exp_echo = 0, exp_busy = 0, exp_err = 0;
  logic [2:0]  exp_state = 3'd0;
  logic [15:0] exp_cnt = 16'd0;

  always @(posedge clk_i) begin
    cyc++;
    if (!rst_ni) begin
      s1 = 0; s2 = 0; m_sched = 0; m_high = 0; m_err_at = -1; m_cnt = 16'd0;
    end else begin
      ts = s2; s2 = s1; s1 = trig_i;
      if (!enable_i) begin
        m_sched = 0;
        m_high  = 0;
      end else if (m_sched) begin
        if (cyc == m_fall) m_cnt = m_cnt + 16'd1;
        if (cyc == m_idle) m_sched = 0;
      end else if (m_high != 0) begin
        if (ts) begin
          if (m_high != 32'hFFFF_FFFF) m_high++;
        end else begin
          if (m_high >= MinTrig) begin
            len_eff = (echo_len_i == 0 || echo_len_i > MaxEcho) ? MaxEcho : echo_len_i;
            m_sched = 1;
            m_bs    = cyc;
            m_rise  = cyc + BurstDly;
            m_fall  = m_rise + len_eff;
            m_idle  = m_fall + Holdoff;
          end else begin
            m_err_at = cyc;
          end
          m_high = 0;
        end
      end else if (ts) begin
        m_high = 1;
      end
    end
    exp_echo  = m_sched && cyc >= m_rise && cyc < m_fall;
    exp_busy  = m_sched;
    exp_err   = (m_err_at == cyc);
    exp_cnt   = m_cnt;
    if (!m_sched)          exp_state = (m_high != 0) ? 3'd1 : 3'd0;
    else if (cyc < m_rise) exp_state = 3'd2;
    else if (cyc < m_fall) exp_state = 3'd3;
    else                   exp_state = 3'd4;
  end

  // Per-cycle comparison and echo edge bookkeeping for the directed checks.
  int     rise_cnt = 0, fall_cnt = 0, err_cnt = 0;
  longint rise_cyc = 0, fall_cyc = 0;
  logic   prev_echo = 0;

  always @(negedge clk_i) begin
    if (rst_ni && cyc > 0) begin
      check("echo_o", echo_o, exp_echo);
      check("busy_o", busy_o, exp_busy);
      check("trig_err_o", trig_err_o, exp_err);
      check("echo_cnt_o", echo_cnt_o, exp_cnt);
      check("state_o", state_o, exp_state);
    end
    if (!rst_ni) begin
      prev_echo = 0;
    end else begin
      if (echo_o && !prev_echo) begin rise_cnt++; rise_cyc = cyc; end
      if (!echo_o && prev_echo) begin fall_cnt++; fall_cyc = cyc; end
      if (trig_err_o) err_cnt++;
      prev_echo = echo_o;
    end
  end

  // Called right after a negedge; returns E, the edge that first samples trig_i low.
  task automatic pulse_trig(input int hi, input logic [31:0] len, output longint e);
    echo_len_i = len;
    trig_i     = 1'b1;
    repeat (hi) @(negedge clk_i);
    trig_i = 1'b0;
    e      = cyc + 1;
  endtask

  task automatic wait_rise(input int budget, input string nm);
    int start = rise_cnt;
    int k     = 0;
    while (rise_cnt == start && k < budget) begin @(negedge clk_i); k++; end
    check(nm, (rise_cnt != start) ? 1 : 0, 1);
  endtask

  task automatic wait_fall(input int budget, input string nm);
    int start = fall_cnt;
    int k     = 0;
    while (fall_cnt == start && k < budget) begin @(negedge clk_i); k++; end
    check(nm, (fall_cnt != start) ? 1 : 0, 1);
  endtask

  longint      e, f;
  int          r0, e0;
  int          r_hi, r_gap;
  logic [31:0] r_len;

  initial begin
    rst_ni = 1'b0; enable_i = 1'b1; trig_i = 1'b0; echo_len_i = 32'd0;
    #1;
    check("reset_outputs", {echo_o, busy_o, trig_err_o, echo_cnt_o, state_o}, 0);
    repeat (3) @(negedge clk_i);
    rst_ni = 1'b1;
    repeat (2) @(negedge clk_i);

    // Nominal: 12-cycle trigger, 37-cycle echo.
    pulse_trig(12, 32'd37, e);
    wait_rise(40, "nominal_rise_seen");
    check("nominal_rise_offset", rise_cyc - e, 22);
    wait_fall(60, "nominal_fall_seen");
    check("nominal_width", fall_cyc - rise_cyc, 37);
    check("nominal_count", echo_cnt_o, 1);
    repeat (60) @(negedge clk_i);

    // Short trigger: error pulse, no echo.
    r0 = rise_cnt; e0 = err_cnt;
    pulse_trig(5, 32'd37, e);
    repeat (40) @(negedge clk_i);
    check("short_err_pulses", err_cnt - e0, 1);
    check("short_no_echo", rise_cnt - r0, 0);
    check("short_count", echo_cnt_o, 1);

    // Clamp and no-object both give the full-range echo.
    pulse_trig(12, 32'd500, e);
    wait_rise(40, "clamp_rise_seen");
    wait_fall(130, "clamp_fall_seen");
    check("clamp_width", fall_cyc - rise_cyc, 100);
    repeat (60) @(negedge clk_i);
    pulse_trig(12, 32'd0, e);
    wait_rise(40, "noobj_rise_seen");
    wait_fall(130, "noobj_fall_seen");
    check("noobj_width", fall_cyc - rise_cyc, 100);
    check("clamp_count", echo_cnt_o, 3);

    // Holdoff: trigger at +10 is swallowed, trigger at +60 is served.
    f = fall_cyc;
    while (cyc < f + 10) @(negedge clk_i);
    r0 = rise_cnt;
    pulse_trig(12, 32'd37, e);
    while (cyc < f + 60) @(negedge clk_i);
    check("holdoff_ignored", rise_cnt - r0, 0);
    pulse_trig(12, 32'd37, e);
    wait_rise(40, "after_holdoff_rise");
    wait_fall(60, "after_holdoff_fall");
    check("holdoff_count", echo_cnt_o, 4);
    repeat (60) @(negedge clk_i);

    // Enable dropped mid-echo: echo ends next edge, count untouched.
    pulse_trig(12, 32'd37, e);
    wait_rise(40, "abort_rise_seen");
    repeat (5) @(negedge clk_i);
    enable_i = 1'b0;
    @(negedge clk_i);
    check("abort_echo_low", echo_o, 0);
    check("abort_state_idle", state_o, 0);
    check("abort_count", echo_cnt_o, 4);
    enable_i = 1'b1;
    repeat (5) @(negedge clk_i);

    // Reset mid-burst clears every output without a clock edge.
    pulse_trig(12, 32'd37, e);
    while (cyc < e + 7) @(negedge clk_i);
    check("burst_before_reset", busy_o, 1);
    #2 rst_ni = 1'b0;
    #1;
    check("async_reset_outputs", {echo_o, busy_o, trig_err_o, echo_cnt_o, state_o}, 0);
    @(negedge clk_i);
    rst_ni = 1'b1;
    repeat (3) @(negedge clk_i);

    // Wrap: preload the echo counter at its maximum.
    #1;
    force dut.echo_cnt_q = 16'hFFFF;
    m_cnt = 16'hFFFF;
    @(negedge clk_i);
    release dut.echo_cnt_q;
    pulse_trig(12, 32'd20, e);
    wait_rise(40, "wrap_rise_seen");
    wait_fall(40, "wrap_fall_seen");
    @(negedge clk_i);
    check("wrap_count", echo_cnt_o, 0);
    repeat (60) @(negedge clk_i);

    // Random triggers, lengths, gaps and enable glitches against the model.
    for (int it = 0; it < 40; it++) begin
      r_hi = $urandom_range(1, 18);
      case ($urandom_range(0, 3))
        0:       r_len = 32'd0;
        1:       r_len = $urandom_range(101, 1000);
        default: r_len = $urandom_range(1, 100);
      endcase
      pulse_trig(r_hi, r_len, e);
      r_gap = $urandom_range(0, 200);
      for (int g = 0; g < r_gap; g++) begin
        enable_i = ($urandom_range(0, 99) != 0);
        if ($urandom_range(0, 15) == 0) echo_len_i = $urandom_range(0, 300);
        @(negedge clk_i);
      end
      enable_i = 1'b1;
    end
    repeat (250) @(negedge clk_i);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
